// File: rtl/uart_pkg.sv
// Shared UART register types, IIR identifiers and character framing helper.
package uart_pkg;

   typedef struct packed {
      logic       dlab;
      logic       set_break;
      logic       stick_par;
      logic       eps;
      logic       pen;
      logic       stb;
      logic [1:0] wls;
   } lcr_t;

   typedef struct packed {
      logic [1:0] rx_trig;
      logic [1:0] rsvd;
      logic       dma_mode;
      logic       tx_rst;
      logic       rx_rst;
      logic       ena;
   } fcr_t;

   typedef struct packed {
      logic fifo_err;
      logic temt;
      logic thre;
      logic bi;
      logic fe;
      logic pe;
      logic oe;
      logic dr;
   } lsr_t;

   typedef struct packed {
      logic edssi;
      logic elsi;
      logic etbei;
      logic erbfi;
   } ier_t;

   localparam logic [2:0] IIR_ID_RLS  = 3'b011;
   localparam logic [2:0] IIR_ID_RDA  = 3'b010;
   localparam logic [2:0] IIR_ID_CTO  = 3'b110;
   localparam logic [2:0] IIR_ID_THRE = 3'b001;
   localparam logic [2:0] IIR_ID_MS   = 3'b000;
   localparam logic [2:0] IIR_ID_NONE = 3'b000;

   // Start + data + parity + stop bits of one character frame (7..12).
   function automatic logic [3:0] char_bits(input lcr_t lcr);
      return 4'd6 + 4'(lcr.wls) + 4'(lcr.pen) + (lcr.stb ? 4'd2 : 4'd1);
   endfunction

endpackage

// File: rtl/uart_char_timer.sv
// Character-timeout timer: counts baud pulses of RX FIFO inactivity up to four character times.
module uart_char_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int TMR_W      = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_pulse_i,
   input  logic fifo_en_i,
   input  logic rx_empty_i,
   input  logic rx_push_i,
   input  logic rx_pop_i,
   input  lcr_t lcr_i,
   output logic cto_o
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] limit;
   logic             clr;

   // Limit follows LCR combinationally so a format change takes effect without restarting the count.
   assign limit = TMR_W'(4 * OVERSAMPLE * int'(char_bits(lcr_i)));
   assign clr   = rx_push_i | rx_pop_i | rx_empty_i | ~fifo_en_i;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (baud_pulse_i && (cnt_q < limit)) begin
         cnt_q <= cnt_q + TMR_W'(1);
      end
   end

   assign cto_o = fifo_en_i & ~rx_empty_i & (cnt_q >= limit);

endmodule

// File: rtl/uart_int_ctrl.sv
// 16550-style interrupt controller: latches sources, masks with IER, arbitrates and registers IIR/irq.
module uart_int_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1),
   parameter int OVERSAMPLE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             baud_pulse_i,
   input  logic [3:0]       ier_i,
   input  logic             fifo_en_i,
   input  logic [3:0]       rx_threshold_i,
   input  logic [7:0]       lcr_i,
   input  logic [CNT_W-1:0] rx_fifo_count_i,
   input  logic             rx_push_i,
   input  logic             rx_pop_i,
   input  logic             tx_fifo_empty_i,
   input  logic             tx_push_i,
   input  logic             rx_oe_i,
   input  logic             rx_pe_i,
   input  logic             rx_fe_i,
   input  logic             rx_bi_i,
   input  logic [3:0]       msr_delta_i,
   input  logic             rd_iir_i,
   input  logic             rd_lsr_i,
   input  logic             rd_msr_i,
   output logic [7:0]       iir_o,
   output logic             irq_o
);

   ier_t       ier;
   logic       rx_empty;
   logic       rda;
   logic       cto;
   logic       rls_q;
   logic       ms_q;
   logic       thre_q;
   logic       tx_empty_q;
   logic       etbei_q;
   logic       thre_set;
   logic       thre_clr;
   logic       any_pend;
   logic [2:0] win_id;
   logic [7:0] iir_q;
   logic       irq_q;

   assign ier      = ier_t'(ier_i);
   assign rx_empty = (rx_fifo_count_i == '0);
   assign rda      = fifo_en_i ? (rx_fifo_count_i >= CNT_W'(rx_threshold_i)) : !rx_empty;

   uart_char_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_char_timer (
      .clk          (clk),
      .rst          (rst),
      .baud_pulse_i (baud_pulse_i),
      .fifo_en_i    (fifo_en_i),
      .rx_empty_i   (rx_empty),
      .rx_push_i    (rx_push_i),
      .rx_pop_i     (rx_pop_i),
      .lcr_i        (lcr_t'(lcr_i)),
      .cto_o        (cto)
   );

   // THRE fires on a TX-empty rising edge, or on etbei being enabled while already empty.
   assign thre_set = tx_fifo_empty_i & (~tx_empty_q | (ier.etbei & ~etbei_q));
   assign thre_clr = tx_push_i | (rd_iir_i & ~iir_q[0] & (iir_q[3:1] == IIR_ID_THRE));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      any_pend = 1'b0;
      win_id   = IIR_ID_NONE;
      if (rls_q && ier.elsi) begin
         any_pend = 1'b1;
         win_id   = IIR_ID_RLS;
      end else if (rda && ier.erbfi) begin
         any_pend = 1'b1;
         win_id   = IIR_ID_RDA;
      end else if (cto && ier.erbfi) begin
         any_pend = 1'b1;
         win_id   = IIR_ID_CTO;
      end else if (thre_q && ier.etbei) begin
         any_pend = 1'b1;
         win_id   = IIR_ID_THRE;
      end else if (ms_q && ier.edssi) begin
         any_pend = 1'b1;
         win_id   = IIR_ID_MS;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rls_q      <= 1'b0;
         ms_q       <= 1'b0;
         thre_q     <= 1'b0;
         tx_empty_q <= 1'b0;
         etbei_q    <= 1'b0;
         iir_q      <= 8'h01;
         irq_q      <= 1'b0;
      end else begin
         // Latched flags ignore IER so unmasking later exposes them.
         rls_q      <= (rx_oe_i | rx_pe_i | rx_fe_i | rx_bi_i) | (rls_q & ~rd_lsr_i);
         ms_q       <= (|msr_delta_i) | (ms_q & ~rd_msr_i);
         if (thre_clr) begin
            thre_q <= 1'b0;
         end else if (thre_set) begin
            thre_q <= 1'b1;
         end
         tx_empty_q <= tx_fifo_empty_i;
         etbei_q    <= ier.etbei;
         iir_q      <= {{2{fifo_en_i}}, 2'b00, win_id, ~any_pend};
         irq_q      <= any_pend;
      end
   end

   assign iir_o = iir_q;
   assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Scoreboard bench for uart_int_ctrl: a rule-level model predicts IIR/irq each cycle, a monitor compares.
module tb_uart_int_ctrl;

   localparam int OVERSAMPLE = 16;
   localparam int CNT_W      = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             baud = 1'b0;
   logic [3:0]       ier = 4'h0;
   logic             fifo_en = 1'b0;
   logic [3:0]       thr = 4'd1;
   logic [7:0]       lcr = 8'h00;
   logic [CNT_W-1:0] count = '0;
   logic             rx_push = 1'b0;
   logic             rx_pop = 1'b0;
   logic             tx_empty = 1'b0;
   logic             tx_push = 1'b0;
   logic             oe = 1'b0, pe = 1'b0, fe = 1'b0, bi = 1'b0;
   logic [3:0]       msr_delta = 4'h0;
   logic             rd_iir = 1'b0, rd_lsr = 1'b0, rd_msr = 1'b0;
   logic [7:0]       iir;
   logic             irq;

   uart_int_ctrl #(
      .FIFO_DEPTH (16),
      .CNT_W      (CNT_W),
      .OVERSAMPLE (OVERSAMPLE)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .baud_pulse_i    (baud),
      .ier_i           (ier),
      .fifo_en_i       (fifo_en),
      .rx_threshold_i  (thr),
      .lcr_i           (lcr),
      .rx_fifo_count_i (count),
      .rx_push_i       (rx_push),
      .rx_pop_i        (rx_pop),
      .tx_fifo_empty_i (tx_empty),
      .tx_push_i       (tx_push),
      .rx_oe_i         (oe),
      .rx_pe_i         (pe),
      .rx_fe_i         (fe),
      .rx_bi_i         (bi),
      .msr_delta_i     (msr_delta),
      .rd_iir_i        (rd_iir),
      .rd_lsr_i        (rd_lsr),
      .rd_msr_i        (rd_msr),
      .iir_o           (iir),
      .irq_o           (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [7:0] iir;
      logic       irq;
      bit         dir_en;
      logic [7:0] dir_iir;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   logic [3:0] thr_tab [4] = '{4'd1, 4'd4, 4'd8, 4'd14};

   // Reference model state: latched sources, previous-cycle edge inputs, idle baud ticks, visible IIR.
   bit         m_rls = 0, m_ms = 0, m_thre = 0, m_ptxe = 0, m_pier1 = 0;
   int         m_idle = 0;
   logic [7:0] m_iir = 8'h01;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   task automatic step(input bit dir_en, input logic [7:0] dir_iir);
      int         bits, limit;
      bit         rda, cto, tclr, tset;
      bit         pend [5];
      bit         en [5];
      logic [2:0] ids [5];
      logic [7:0] nxt;
      exp_t       e;
      ids   = '{3'b011, 3'b010, 3'b110, 3'b001, 3'b000};
      bits  = 1 + (5 + int'(lcr[1:0])) + int'(lcr[3]) + (lcr[2] ? 2 : 1);
      limit = 4 * OVERSAMPLE * bits;
      rda   = fifo_en ? (count >= thr) : (count != 0);
      cto   = fifo_en && (count != 0) && (m_idle >= limit);
      pend  = '{m_rls, rda, cto, m_thre, m_ms};
      en    = '{ier[2], ier[0], ier[0], ier[1], ier[3]};
      nxt   = {fifo_en, fifo_en, 6'b000001};
      for (int i = 0; i < 5; i++) begin
         if (pend[i] && en[i]) begin
            nxt[3:1] = ids[i];
            nxt[0]   = 1'b0;
            break;
         end
      end
      if (rst) begin
         nxt = 8'h01;
         m_rls = 0; m_ms = 0; m_thre = 0; m_ptxe = 0; m_pier1 = 0; m_idle = 0;
      end else begin
         tclr   = tx_push || (rd_iir && !m_iir[0] && m_iir[3:1] == 3'b001);
         tset   = tx_empty && (!m_ptxe || (ier[1] && !m_pier1));
         m_thre = tclr ? 1'b0 : (tset ? 1'b1 : m_thre);
         m_rls  = (oe || pe || fe || bi) || (m_rls && !rd_lsr);
         m_ms   = (msr_delta != 0) || (m_ms && !rd_msr);
         m_ptxe  = tx_empty;
         m_pier1 = ier[1];
         if (rx_push || rx_pop || count == 0 || !fifo_en) m_idle = 0;
         else if (baud && m_idle < limit) m_idle++;
      end
      m_iir     = nxt;
      e.due     = cyc + 1;
      e.iir     = nxt;
      e.irq     = ~nxt[0];
      e.dir_en  = dir_en;
      e.dir_iir = dir_iir;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      baud = 0; rx_push = 0; rx_pop = 0; tx_push = 0;
      oe = 0; pe = 0; fe = 0; bi = 0; msr_delta = 4'h0;
      rd_iir = 0; rd_lsr = 0; rd_msr = 0;
   endtask

   task automatic apply();
      step(1'b0, 8'h00);
   endtask

   task automatic expect_iir(input logic [7:0] v);
      step(1'b1, v);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            n_vec++;
            check("iir", iir, e.iir);
            check("irq", {7'b0, irq}, {7'b0, e.irq});
            if (e.dir_en) begin
               check("dir_iir", iir, e.dir_iir);
               check("dir_irq", {7'b0, irq}, {7'b0, ~e.dir_iir[0]});
            end
         end
      end
   end

   initial begin : driver
      @(posedge clk);
      #1;
      apply();
      expect_iir(8'h01);
      rst = 0;

      // THRE edge, then cleared by reading IIR
      ier = 4'hF; fifo_en = 1; tx_empty = 1;
      apply();
      expect_iir(8'hC2);
      rd_iir = 1; apply();
      expect_iir(8'hC1);

      // RDA threshold, RLS pre-empts, LSR read releases it
      thr = 4'd4; count = 5'd3; apply();
      count = 5'd4; expect_iir(8'hC4);
      pe = 1; expect_iir(8'hC4);
      expect_iir(8'hC6);
      rd_lsr = 1; expect_iir(8'hC6);
      expect_iir(8'hC4);
      count = 5'd3; expect_iir(8'hC1);

      // character timeout at 640 pulses for a 10-bit frame
      lcr = 8'h03; count = 5'd1; rx_push = 1; apply();
      for (int i = 0; i < 640; i++) begin
         baud = 1; apply();
         if (i == 638) expect_iir(8'hC1);
         else if (i == 639) expect_iir(8'hCC);
         else apply();
      end
      rx_pop = 1; expect_iir(8'hCC);
      expect_iir(8'hC1);
      for (int i = 0; i < 639; i++) begin
         baud = 1; apply();
         apply();
      end
      rx_pop = 1; apply();
      repeat (8) begin baud = 1; apply(); end
      expect_iir(8'hC1);

      // same-cycle set/clear races
      pe = 1; rd_lsr = 1; apply();
      expect_iir(8'hC6);
      rd_lsr = 1; expect_iir(8'hC6);
      expect_iir(8'hC1);
      tx_empty = 0; apply();
      tx_empty = 1; tx_push = 1; apply();
      apply();
      expect_iir(8'hC1);

      // masked latching, then unmask modem status
      ier = 4'h0; apply();
      tx_empty = 0; apply();
      tx_empty = 1; pe = 1; msr_delta = 4'h2; apply();
      apply();
      expect_iir(8'hC1);
      ier = 4'h8; expect_iir(8'hC0);

      // non-FIFO RDA
      rd_lsr = 1; rd_msr = 1; apply();
      ier = 4'h1; fifo_en = 0; count = 5'd1; expect_iir(8'h04);

      // LCR shortens the limit below the current count
      fifo_en = 1; lcr = 8'h03; rx_push = 1; apply();
      repeat (500) begin baud = 1; apply(); end
      lcr = 8'h00; expect_iir(8'hCC);

      // reset mid-timeout restarts the count from zero
      lcr = 8'h03; rx_push = 1; apply();
      repeat (100) begin baud = 1; apply(); end
      rst = 1; expect_iir(8'h01);
      rst = 0;
      repeat (639) begin baud = 1; apply(); end
      expect_iir(8'hC1);
      baud = 1; apply();
      expect_iir(8'hCC);

      // randomized: alternating quiet (timeout) and busy bursts
      for (int b = 0; b < 12; b++) begin
         lcr     = 8'($urandom);
         fifo_en = ($urandom_range(0, 7) != 0);
         thr     = thr_tab[$urandom_range(0, 3)];
         ier     = 4'($urandom);
         if (b % 2 == 0) begin
            count = 5'($urandom_range(1, 16)); rx_push = 1; apply();
            repeat (850) begin
               baud   = ($urandom_range(0, 7) != 0);
               rd_iir = ($urandom_range(0, 63) == 0);
               if ($urandom_range(0, 299) == 0) lcr = 8'($urandom);
               apply();
            end
         end else begin
            repeat (80) begin
               rst     = ($urandom_range(0, 99) == 0);
               baud    = 1'($urandom_range(0, 1));
               rx_push = ($urandom_range(0, 3) == 0) && (count < 16);
               rx_pop  = ($urandom_range(0, 3) == 0) && (count > 0);
               if (rx_push) count++;
               if (rx_pop) count--;
               oe = ($urandom_range(0, 15) == 0);
               pe = ($urandom_range(0, 15) == 0);
               fe = ($urandom_range(0, 15) == 0);
               bi = ($urandom_range(0, 15) == 0);
               msr_delta = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
               rd_iir  = ($urandom_range(0, 3) == 0);
               rd_lsr  = ($urandom_range(0, 3) == 0);
               rd_msr  = ($urandom_range(0, 3) == 0);
               tx_push = ($urandom_range(0, 7) == 0);
               if ($urandom_range(0, 5) == 0) tx_empty = ~tx_empty;
               if ($urandom_range(0, 9) == 0) ier = 4'($urandom);
               if ($urandom_range(0, 19) == 0) fifo_en = ~fifo_en;
               apply();
            end
            rst = 0;
         end
      end

      for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (sb_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected outputs never compared, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_int_ctrl.md
Name: uart_int_ctrl

Overview:
16550-style interrupt controller and priority arbiter for the UART register block.
- Collects five interrupt sources: line status, RX data available, character timeout, THR empty and modem status.
- Masks them with IER and arbitrates by fixed 16550 priority.
- Produces the IIR read value and a single registered irq line.
- Owns the character-timeout timer, driven by the shared baud pulse.

Parameters:
FIFO_DEPTH, 16, RX/TX FIFO depth in bytes
CNT_W, 5, width of rx_fifo_count_i (holds 0..FIFO_DEPTH)
OVERSAMPLE, 16, baud pulses per bit time

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
baud_pulse_i  in  1  one-cycle baud tick (OVERSAMPLE per bit)
ier_i  in  4  [0] erbfi RX data, [1] etbei THRE, [2] elsi line status, [3] edssi modem status
fifo_en_i  in  1  FCR.ena
rx_threshold_i  in  4  RX trigger level (1/4/8/14)
lcr_i  in  8  LCR (wls, stb, pen used)
rx_fifo_count_i  in  CNT_W  RX FIFO occupancy
rx_push_i  in  1  character written into RX FIFO
rx_pop_i  in  1  host read of RHR
tx_fifo_empty_i  in  1  TX FIFO empty
tx_push_i  in  1  host write of THR
rx_oe_i, rx_pe_i, rx_fe_i, rx_bi_i  in  1 each  error pulses from receiver
msr_delta_i  in  4  MSR delta bits (DCTS, DDSR, TERI, DDCD)
rd_iir_i  in  1  host read of addr 2
rd_lsr_i  in  1  host read of addr 5
rd_msr_i  in  1  host read of addr 6
iir_o  out  8  IIR value
irq_o  out  1  interrupt request, active high

Behaviour:
- Reset: iir_o=8'h01 (fifo bits 0), irq_o=0, all pending flags 0, timeout counter 0.
- Pending sources, in priority order:
  - RLS (id 3'b011): set on any rx_*_i pulse; cleared on rd_lsr_i. Set wins if both occur in the same cycle.
  - RDA (id 3'b010): level, not latched.
    - fifo_en_i=1: rx_fifo_count_i >= rx_threshold_i.
    - fifo_en_i=0: rx_fifo_count_i != 0.
  - CTO (id 3'b110): only when fifo_en_i=1; see timer below.
  - THRE (id 3'b001): set on the rising edge of tx_fifo_empty_i, or on the rising edge of ier_i[1] while the FIFO is empty.
    - Cleared by tx_push_i.
    - Cleared by rd_iir_i when the currently reported id is THRE.
    - A tx_push_i in the same cycle as a set: the clear wins.
  - MS (id 3'b000): set when |msr_delta_i; cleared on rd_msr_i. Set wins if both occur in the same cycle.
- Masking:
  - Each source is gated by its IER bit. RLS uses elsi; RDA and CTO use erbfi; THRE uses etbei; MS uses edssi.
  - Latched flags keep accumulating while masked, so unmasking exposes them.
- Arbitration: the highest-priority enabled pending source wins.
- IIR format:
  - iir_o[0] = 0 when any source is pending, else 1.
  - iir_o[3:1] = winning id (3'b000 when none is pending).
  - iir_o[5:4] = 0.
  - iir_o[7:6] = {2{fifo_en_i}}.
- Timing:
  - iir_o and irq_o are registered: one cycle from a source change to the output.
  - irq_o = ~iir_o[0], registered alongside iir_o.
  - rd_iir_i samples the iir_o visible in that cycle.
- Character timer:
  - bits = 1 + (5+wls) + pen + (stb?2:1), range 7..12.
  - limit = 4*OVERSAMPLE*bits (448..768); 10-bit counter.
  - Counter clears on rx_push_i, on rx_pop_i, when rx_fifo_count_i==0, or when fifo_en_i==0.
  - Otherwise it increments on baud_pulse_i and saturates at limit.
  - At limit with the FIFO non-empty, CTO is pending until the counter clears.
  - An LCR change mid-count recomputes the limit immediately with no counter reset. If the counter is already >= the new limit, CTO asserts next cycle.
- Reset during operation: all state returns to reset values in the next cycle regardless of inputs.

Decomposition:
- Shared package uart_pkg holds:
  - lcr_t, fcr_t, lsr_t (moved out of the register block);
  - ier_t (packed: edssi, elsi, etbei, erbfi);
  - localparams IIR_ID_RLS/RDA/CTO/THRE/MS/NONE;
  - function char_bits(lcr_t).
- One sub-module: uart_char_timer, holding the timeout counter, limit computation and cto_o.

Test Plan:
- Reset, then ier=4'hF, fifo_en=1, tx_fifo_empty=1 → THRE edge → iir_o=8'hC2, irq_o=1. rd_iir → iir_o=8'hC1, irq_o=0 two cycles later.
- threshold=4, count steps 3→4 → iir_o=8'hC4. Inject rx_pe pulse → iir_o=8'hC6. rd_lsr → back to 8'hC4. Count 4→3 → 8'hC1.
- wls=3, pen=0, stb=0 (bits=10), count=1, no activity → CTO after exactly 640 baud pulses: iir_o=8'hCC. rx_pop at pulse 639 → restart, no CTO.
- rx_pe and rd_lsr in the same cycle → RLS stays pending (8'hC6). tx_push and THRE edge in the same cycle → THRE not set.
- ier=4'h0 with RLS, MS and THRE all latched → iir_o=8'hC1, irq=0. Set ier=4'h8 → 8'hC0, irq=1 next cycle.
- fifo_en=0, count=1 → iir_o=8'h04. rst asserted mid-timeout → iir_o=8'h01, counter 0.
